mv_select: RTL

Best-match motion-vector selector for the full-search motion estimation datapath. It consumes the stream of SAD (sum of absolute differences) values produced for every candidate position of one macroblock's search window. It tracks the running minimum and emits one signed motion vector (mvx, mvy) per macroblock. It sits directly upstream of the motion-vector store and drives that store's 4-bit mvx/mvy inputs, holding them stable between results.

---
 rtl/mv_select.sv | 116 +++++++++++
 1 files changed

// File: rtl/mv_select.sv
// Best-match motion-vector selector: tracks the minimum SAD over one macroblock's search
// window and reports the winning candidate as a signed (mvx, mvy) pair.
module mv_select #(
  parameter int unsigned SAD_W = 16,
  parameter int unsigned MV_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad,
  input  logic             mb_clear,
  output logic [MV_W-1:0]  mvx,
  output logic [MV_W-1:0]  mvy,
  output logic [SAD_W-1:0] min_sad,
  output logic             mv_valid,
  output logic             busy,
  output logic [15:0]      mb_count
);

  localparam int unsigned IdxW = 2 * MV_W;
  // Offset-to-signed mapping: subtracting 2^(MV_W-1) equals flipping the MSB.
  localparam logic [MV_W-1:0] MsbFlip = MV_W'(1) << (MV_W - 1);

  typedef enum logic {StIdle, StSearch} phase_e;

  phase_e            phase_q, phase_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   best_idx_q, best_idx_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [MV_W-1:0]   mvx_q, mvx_d, mvy_q, mvy_d;
  logic [SAD_W-1:0]  min_sad_q, min_sad_d;
  logic              mv_valid_q, mv_valid_d;
  logic [15:0]       mb_count_q, mb_count_d;

  logic              accept, last, take;
  logic [IdxW-1:0]   win_idx;
  logic [SAD_W-1:0]  win_sad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= StIdle;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_sad_q <= '0;
      mvx_q      <= '0;
      mvy_q      <= '0;
      min_sad_q  <= '0;
      mv_valid_q <= 1'b0;
      mb_count_q <= '0;
    end else begin
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_sad_q <= best_sad_d;
      mvx_q      <= mvx_d;
      mvy_q      <= mvy_d;
      min_sad_q  <= min_sad_d;
      mv_valid_q <= mv_valid_d;
      mb_count_q <= mb_count_d;
    end
  end

  // Strict less-than keeps the earliest candidate on ties; candidate 0 always seeds.
  always_comb begin
    accept  = sad_valid && !mb_clear;
    last    = (idx_q == '1);
    take    = (idx_q == '0) || (sad < best_sad_q);
    win_idx = take ? idx_q : best_idx_q;
    win_sad = take ? sad : best_sad_q;

    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_sad_d = best_sad_q;
    mvx_d      = mvx_q;
    mvy_d      = mvy_q;
    min_sad_d  = min_sad_q;
    mv_valid_d = 1'b0;
    mb_count_d = mb_count_q;

    if (mb_clear) begin
      idx_d      = '0;
      best_idx_d = '0;
      best_sad_d = '0;
    end else if (sad_valid) begin
      idx_d      = idx_q + 1'b1;
      best_idx_d = win_idx;
      best_sad_d = win_sad;
      if (last) begin
        mvx_d      = win_idx[MV_W-1:0] ^ MsbFlip;
        mvy_d      = win_idx[IdxW-1:MV_W] ^ MsbFlip;
        min_sad_d  = win_sad;
        mv_valid_d = 1'b1;
        mb_count_d = mb_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      StIdle:   if (accept) phase_d = StSearch;
      StSearch: if (mb_clear || (accept && last)) phase_d = StIdle;
      default:  phase_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (phase_q == StSearch);
    mvx      = mvx_q;
    mvy      = mvy_q;
    min_sad  = min_sad_q;
    mv_valid = mv_valid_q;
    mb_count = mb_count_q;
  end

endmodule
